// File: rtl/id_imm_ext_if.sv
// id_imm_ext_if: decode-side immediate stream and EX-side result stream for id_imm_ext_buf
interface id_imm_ext_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [IN_W-1:0]  in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       count;
  modport master (
    output flush, in_valid, in_mode, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, count
  );
  modport slave (
    input  flush, in_valid, in_mode, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, count
  );
endinterface

// File: rtl/id_imm_ext_buf.sv
// id_imm_ext_buf: immediate extension into a 2-entry head/skid buffer; optional
// same-cycle bypass when empty is compiled in with ID_IMM_EXT_BYPASS_EN.
module id_imm_ext_buf #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst_n,
  id_imm_ext_if.slave bus
);
  if (IN_W < 2 || OUT_W < IN_W + SHIFT) begin : g_bad_params
    $error("id_imm_ext_buf: need IN_W >= 2 and OUT_W >= IN_W + SHIFT");
  end
  logic [1:0]             cnt;
  logic [OUT_W-1:0]       head_d, skid_d, zx, sx, ext;
  logic [TAG_W-1:0]       head_t, skid_t;
  logic signed [IN_W-1:0] simm;
  logic                   byp, push, pop, head_v;
  always_comb begin
    simm = $signed(bus.in_imm);
    zx   = OUT_W'(bus.in_imm);
    sx   = OUT_W'(simm);
    ext  = bus.in_mode == 2'd0 ? zx :
           bus.in_mode == 2'd1 ? sx :
           bus.in_mode == 2'd2 ? zx << (OUT_W - IN_W) : sx << SHIFT;
  end
  assign head_v = cnt != 2'd0;
`ifdef ID_IMM_EXT_BYPASS_EN
  assign byp = !head_v && bus.in_valid && bus.out_ready && !bus.flush;
`else
  assign byp = 1'b0;
`endif
  assign push = bus.in_valid && cnt != 2'd2 && !bus.flush && !byp;
  assign pop  = head_v && bus.out_ready && !bus.flush;
  assign bus.in_ready  = cnt != 2'd2;
  assign bus.count     = cnt;
  assign bus.out_valid = head_v || byp;
  assign bus.out_data  = byp ? ext : head_d;
  assign bus.out_tag   = byp ? bus.in_tag : head_t;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      head_d <= '0;
      head_t <= '0;
      skid_d <= '0;
      skid_t <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
      // head keeps its last value when nothing replaces it, so outputs hold while idle
      if (pop && cnt == 2'd2) begin
        head_d <= skid_d;
        head_t <= skid_t;
      end else if (push && (cnt == 2'd0 || pop)) begin
        head_d <= ext;
        head_t <= bus.in_tag;
      end
      if (push && !pop && cnt == 2'd1) begin
        skid_d <= ext;
        skid_t <= bus.in_tag;
      end
    end
  end
endmodule

// File: tb/tb_id_imm_ext_buf.sv
// tb_id_imm_ext_buf: vector table, hand sequences and random traffic against a queue model
module tb_id_imm_ext_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  id_imm_ext_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();
  id_imm_ext_buf #(.IN_W(16), .OUT_W(32), .SHIFT(2), .TAG_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];
  logic [36:0] q[$];
`ifdef ID_IMM_EXT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] imm);
    longint v;
    v = longint'(imm);
    if (m[0] && imm[15]) v = v - 65536;
    if (m == 2'd2) v = longint'(imm) * 65536;
    if (m == 2'd3) v = v * 4;
    return v[31:0];
  endfunction
  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm, input logic [4:0] t);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_imm   = imm;
    bus.in_tag   = t;
  endtask
  initial begin
    int pushed, popped, cyc;
    logic byp, pop, push;
    logic [36:0] exp_head;
    vecs[0] = '{2'd0, 16'h0001, 5'd1, 32'h0000_0001};
    vecs[1] = '{2'd1, 16'h0001, 5'd2, 32'h0000_0001};
    vecs[2] = '{2'd0, 16'hF000, 5'd3, 32'h0000_F000};
    vecs[3] = '{2'd1, 16'hF000, 5'd4, 32'hFFFF_F000};
    vecs[4] = '{2'd2, 16'hF000, 5'd5, 32'hF000_0000};
    vecs[5] = '{2'd3, 16'hF000, 5'd6, 32'hFFFF_C000};
    vecs[6] = '{2'd1, 16'h8000, 5'd7, 32'hFFFF_8000};
    vecs[7] = '{2'd3, 16'h7FFF, 5'd8, 32'h0001_FFFC};
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    // table: one item each, out_ready held high
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b1;
      drive(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].tag);
      if (BYP) begin
        #1;
        chk("vec_byp_valid", 64'(bus.out_valid), 64'd1);
        chk("vec_byp_data", 64'(bus.out_data), 64'(vecs[i].exp));
        chk("vec_byp_tag", 64'(bus.out_tag), 64'(vecs[i].tag));
        tick();
        bus.in_valid = 1'b0;
        chk("vec_byp_count", 64'(bus.count), 64'd0);
      end else begin
        #1;
        chk("vec_no_early", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("vec_valid", 64'(bus.out_valid), 64'd1);
        chk("vec_data", 64'(bus.out_data), 64'(vecs[i].exp));
        chk("vec_tag", 64'(bus.out_tag), 64'(vecs[i].tag));
        chk("vec_count1", 64'(bus.count), 64'd1);
        tick();
        chk("vec_count0", 64'(bus.count), 64'd0);
        chk("vec_hold_data", 64'(bus.out_data), 64'(vecs[i].exp));
      end
    end
    // back-pressure: tags 1,2 accepted, 3 held until room
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, 16'h0011, 5'd1);
    tick();
    bus.in_tag = 5'd2;
    bus.in_imm = 16'h0022;
    tick();
    bus.in_tag = 5'd3;
    bus.in_imm = 16'h0033;
    tick();
    chk("bp_count2", 64'(bus.count), 64'd2);
    chk("bp_ready0", 64'(bus.in_ready), 64'd0);
    chk("bp_head1", 64'(bus.out_tag), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_head2", 64'(bus.out_tag), 64'd2);
    chk("bp_data2", 64'(bus.out_data), 64'h22);
    chk("bp_count_after_pop", 64'(bus.count), 64'd1);
    chk("bp_ready1", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("pp_count_stays1", 64'(bus.count), 64'd1);
    chk("pp_head3", 64'(bus.out_tag), 64'd3);
    chk("pp_data3", 64'(bus.out_data), 64'h33);
    tick();
    chk("bp_drained", 64'(bus.count), 64'd0);
    // flush at full, flush-cycle input dropped
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, 16'h0044, 5'd4);
    tick();
    drive(1'b1, 2'd0, 16'h0055, 5'd5);
    tick();
    chk("fl_count2", 64'(bus.count), 64'd2);
    bus.flush = 1'b1;
    drive(1'b1, 2'd0, 16'h0066, 5'd6);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_count0", 64'(bus.count), 64'd0);
    chk("fl_valid0", 64'(bus.out_valid), 64'd0);
    chk("fl_hold_tag", 64'(bus.out_tag), 64'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", 64'(bus.out_valid), 64'd0);
    end
    // random traffic against the queue model
    pushed = 0;
    popped = 0;
    cyc = 0;
    q.delete();
    while (popped < 1000 && cyc < 20000) begin
      drive(pushed < 1000 && $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            16'($urandom), 5'($urandom));
      bus.out_ready = $urandom_range(0, 3) != 0;
      #1;
      byp = BYP && q.size() == 0 && bus.in_valid && bus.out_ready;
      exp_head = byp ? {bus.in_tag, ref_ext(bus.in_mode, bus.in_imm)} :
                 (q.size() > 0 ? q[0] : 37'd0);
      chk("rnd_valid", 64'(bus.out_valid), 64'(q.size() > 0 || byp));
      chk("rnd_count", 64'(bus.count), 64'(q.size()));
      chk("rnd_ready", 64'(bus.in_ready), 64'(q.size() != 2));
      if (q.size() > 0 || byp)
        chk("rnd_head", 64'({bus.out_tag, bus.out_data}), 64'(exp_head));
      pop  = q.size() > 0 && bus.out_ready;
      push = bus.in_valid && q.size() != 2 && !byp;
      if (pop || byp) popped++;
      if (push || byp) pushed++;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({bus.in_tag, ref_ext(bus.in_mode, bus.in_imm)});
      tick();
      cyc++;
    end
    chk("rnd_completed", 64'(popped), 64'd1000);
    // asynchronous reset with items buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd1, 16'h8000, 5'd9);
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("ar_pre_count", 64'(bus.count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_count", 64'(bus.count), 64'd0);
    chk("ar_data", 64'(bus.out_data), 64'd0);
    chk("ar_tag", 64'(bus.out_tag), 64'd0);
    chk("ar_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_stays_empty", 64'(bus.out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
